// File: rtl/cc_level_sequencer_pkg.sv
// Shared constants for the level sequencer slice: state encoding, level codes,
// default row lengths and output widths.
package cc_level_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t STATE_IDLE = 2'd0;
  localparam state_t STATE_RUN  = 2'd1;
  localparam state_t STATE_WIN  = 2'd2;

  localparam int unsigned CURRENTLEVEL_W  = 3;
  localparam int unsigned LEVELPROGRESS_W = 5;

  // Level codes: odd codes are transition images, even non-zero codes are
  // playable levels, 0 is the blank/idle code and 7 is never generated.
  localparam int unsigned LVL_BLANK   = 0;
  localparam int unsigned LVL_INTRO   = 1;
  localparam int unsigned LVL_GAME1   = 2;
  localparam int unsigned LVL_GAME2   = 4;
  localparam int unsigned LVL_GAME3   = 6;
  localparam int unsigned LVL_INVALID = 7;

  localparam int unsigned DEF_LEN_TRANSITION = 8;
  localparam int unsigned DEF_LEN_LVL1       = 10;
  localparam int unsigned DEF_LEN_LVL2       = 15;
  localparam int unsigned DEF_LEN_LVL3       = 20;

endpackage

// File: rtl/cc_level_sequencer_length.sv
// Combinational level-code to row-length lookup. Module name kept as
// cc_level_length because the display timing logic instantiates it too.
import cc_level_sequencer_pkg::*;

module cc_level_length #(
  parameter int unsigned LEVEL_W        = CURRENTLEVEL_W,
  parameter int unsigned LEN_W          = LEVELPROGRESS_W,
  parameter int unsigned LEN_TRANSITION = DEF_LEN_TRANSITION,
  parameter int unsigned LEN_LVL1       = DEF_LEN_LVL1,
  parameter int unsigned LEN_LVL2       = DEF_LEN_LVL2,
  parameter int unsigned LEN_LVL3       = DEF_LEN_LVL3
) (
  input  logic [LEVEL_W-1:0] levelCode,
  output logic [LEN_W-1:0]   levelLen
);

  // Odd codes below 7 are transitions, even codes are levels, 0/7 have no rows.
  always_comb begin
    levelLen = '0;
    if (levelCode == LEVEL_W'(LVL_GAME1)) begin
      levelLen = LEN_W'(LEN_LVL1);
    end else if (levelCode == LEVEL_W'(LVL_GAME2)) begin
      levelLen = LEN_W'(LEN_LVL2);
    end else if (levelCode == LEVEL_W'(LVL_GAME3)) begin
      levelLen = LEN_W'(LEN_LVL3);
    end else if (levelCode[0] && levelCode != LEVEL_W'(LVL_INVALID)) begin
      levelLen = LEN_W'(LEN_TRANSITION);
    end
  end

endmodule

// File: rtl/cc_level_sequencer.sv
// Level sequencer: walks intro -> level 1 -> transition -> level 2 ->
// transition -> level 3 -> win on scroll ticks, restarts the current level on
// a crash and reports level/row to the data handler.
// Optional build macro CC_LEVEL_SEQUENCER_LIVES_EN adds a lives counter and
// the GameOver pulse; without it lives are unlimited and GameOver is 0.
import cc_level_sequencer_pkg::*;

module cc_level_sequencer #(
  parameter int unsigned CURRENTLEVEL_DATAWIDTH  = CURRENTLEVEL_W,
  parameter int unsigned LEVELPROGRESS_DATAWIDTH = LEVELPROGRESS_W,
  parameter int unsigned LEN_TRANSITION          = DEF_LEN_TRANSITION,
  parameter int unsigned LEN_LVL1                = DEF_LEN_LVL1,
  parameter int unsigned LEN_LVL2                = DEF_LEN_LVL2,
  parameter int unsigned LEN_LVL3                = DEF_LEN_LVL3,
  parameter int unsigned LEVEL_LAST              = LVL_GAME3
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
  ,
  parameter int unsigned LIVES_INIT              = 3
`endif
) (
  input  logic                               CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                               CC_LEVEL_SEQUENCER_RESET_InHigh,
  input  logic                               CC_LEVEL_SEQUENCER_Start_In,
  input  logic                               CC_LEVEL_SEQUENCER_Tick_In,
  input  logic                               CC_LEVEL_SEQUENCER_Crash_In,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl_Out,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress_Out,
  output logic                               CC_LEVEL_SEQUENCER_Playing_Out,
  output logic                               CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                               CC_LEVEL_SEQUENCER_Win_Out,
  output logic                               CC_LEVEL_SEQUENCER_GameOver_Out
);

  localparam int unsigned LW = CURRENTLEVEL_DATAWIDTH;
  localparam int unsigned PW = LEVELPROGRESS_DATAWIDTH;

  state_t          stateReg, stateNext;
  logic [LW-1:0]   lvlReg, lvlNext;
  logic [PW-1:0]   progReg, progNext;
  logic [PW-1:0]   lvlLen;
  logic            playingReg, playingNext;
  logic            doneReg, doneNext;
  logic            winReg, winNext;
  logic            gameOverNext;

`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
  localparam int unsigned LIVES_W = (LIVES_INIT < 2) ? 1 : $clog2(LIVES_INIT + 1);
  logic [LIVES_W-1:0] livesReg, livesNext;
  logic               gameOverReg;
`endif

  cc_level_length #(
    .LEVEL_W        (LW),
    .LEN_W          (PW),
    .LEN_TRANSITION (LEN_TRANSITION),
    .LEN_LVL1       (LEN_LVL1),
    .LEN_LVL2       (LEN_LVL2),
    .LEN_LVL3       (LEN_LVL3)
  ) uLength (
    .levelCode (lvlReg),
    .levelLen  (lvlLen)
  );

  // Next-state, next-level and next-progress decision for one clock.
  always_comb begin
    stateNext    = stateReg;
    lvlNext      = lvlReg;
    progNext     = progReg;
    doneNext     = 1'b0;
    gameOverNext = 1'b0;
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
    livesNext    = livesReg;
`endif
    case (stateReg)
      STATE_IDLE: begin
        lvlNext  = LW'(LVL_BLANK);
        progNext = '0;
        if (CC_LEVEL_SEQUENCER_Start_In) begin
          stateNext = STATE_RUN;
          lvlNext   = LW'(LVL_INTRO);
          progNext  = PW'(1);
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
          livesNext = LIVES_W'(LIVES_INIT);
`endif
        end
      end
      STATE_RUN: begin
        if (lvlReg == LW'(LVL_INVALID)) begin
          stateNext = STATE_IDLE;
          lvlNext   = LW'(LVL_BLANK);
          progNext  = '0;
        end else if (CC_LEVEL_SEQUENCER_Crash_In && playingReg) begin
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
          if (livesReg <= LIVES_W'(1)) begin
            stateNext    = STATE_IDLE;
            lvlNext      = LW'(LVL_BLANK);
            progNext     = '0;
            livesNext    = '0;
            gameOverNext = 1'b1;
          end else begin
            progNext  = PW'(1);
            livesNext = livesReg - LIVES_W'(1);
          end
`else
          progNext = PW'(1);
`endif
        end else if (CC_LEVEL_SEQUENCER_Tick_In) begin
          // >= rather than == keeps progress clamped to 0..len even if it
          // were ever out of range.
          if (progReg < lvlLen) begin
            progNext = progReg + PW'(1);
          end else if (lvlReg < LW'(LEVEL_LAST)) begin
            lvlNext  = lvlReg + LW'(1);
            progNext = PW'(1);
            doneNext = 1'b1;
          end else begin
            stateNext = STATE_WIN;
            progNext  = '0;
            doneNext  = 1'b1;
          end
        end
      end
      STATE_WIN: begin
        progNext = '0;
        if (CC_LEVEL_SEQUENCER_Start_In) begin
          stateNext = STATE_RUN;
          lvlNext   = LW'(LVL_INTRO);
          progNext  = PW'(1);
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
          livesNext = LIVES_W'(LIVES_INIT);
`endif
        end
      end
      default: begin
        stateNext = STATE_IDLE;
        lvlNext   = LW'(LVL_BLANK);
        progNext  = '0;
      end
    endcase
    playingNext = (stateNext == STATE_RUN) && (lvlNext != '0) && !lvlNext[0];
    winNext     = (stateNext == STATE_WIN);
  end

  // Registered state and outputs; reset overrides every other input.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
      stateReg   <= STATE_IDLE;
      lvlReg     <= '0;
      progReg    <= '0;
      playingReg <= 1'b0;
      doneReg    <= 1'b0;
      winReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      lvlReg     <= lvlNext;
      progReg    <= progNext;
      playingReg <= playingNext;
      doneReg    <= doneNext;
      winReg     <= winNext;
    end
  end

`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
  // Lives counter and one-cycle game-over pulse.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
      livesReg    <= '0;
      gameOverReg <= 1'b0;
    end else begin
      livesReg    <= livesNext;
      gameOverReg <= gameOverNext;
    end
  end

  assign CC_LEVEL_SEQUENCER_GameOver_Out = gameOverReg;
`else
  assign CC_LEVEL_SEQUENCER_GameOver_Out = gameOverNext;
`endif

  assign CC_LEVEL_SEQUENCER_CurrentLvl_Out  = lvlReg;
  assign CC_LEVEL_SEQUENCER_LvlProgress_Out = progReg;
  assign CC_LEVEL_SEQUENCER_Playing_Out     = playingReg;
  assign CC_LEVEL_SEQUENCER_LevelDone_Out   = doneReg;
  assign CC_LEVEL_SEQUENCER_Win_Out         = winReg;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Self-checking bench for cc_level_sequencer: a game-level model is stepped
// alongside the DUT and compared every cycle, with literal checks at key points.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, tick, crash;
  logic [2:0] lvl;
  logic [4:0] prog;
  logic       playing, done, win, gameOver;

  always #5 clk = ~clk;

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50        (clk),
    .CC_LEVEL_SEQUENCER_RESET_InHigh    (rst),
    .CC_LEVEL_SEQUENCER_Start_In        (start),
    .CC_LEVEL_SEQUENCER_Tick_In         (tick),
    .CC_LEVEL_SEQUENCER_Crash_In        (crash),
    .CC_LEVEL_SEQUENCER_CurrentLvl_Out  (lvl),
    .CC_LEVEL_SEQUENCER_LvlProgress_Out (prog),
    .CC_LEVEL_SEQUENCER_Playing_Out     (playing),
    .CC_LEVEL_SEQUENCER_LevelDone_Out   (done),
    .CC_LEVEL_SEQUENCER_Win_Out         (win),
    .CC_LEVEL_SEQUENCER_GameOver_Out    (gameOver)
  );

  // Game model: which screen we are on and which row of it.
  int  rows [0:7] = '{0, 8, 10, 8, 15, 8, 20, 0};
  bit  inGame, won;
  int  mLvl, mProg, mLives;
  bit  mDone, mOver;

  int  errors = 0;
  int  checks = 0;
  bit  cmpEn  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic newGame();
    inGame = 1; won = 0; mLvl = 1; mProg = 1; mLives = 3;
  endtask

  task automatic modelStep(input bit r, input bit s, input bit t, input bit c);
    mDone = 0; mOver = 0;
    if (r) begin
      inGame = 0; won = 0; mLvl = 0; mProg = 0; mLives = 0;
    end else if (!inGame) begin
      if (s) newGame();
    end else if (won) begin
      if (s) newGame();
    end else if (c && (mLvl % 2 == 0)) begin
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
      mLives--;
      if (mLives == 0) begin
        inGame = 0; mLvl = 0; mProg = 0; mOver = 1;
      end else mProg = 1;
`else
      mProg = 1;
`endif
    end else if (t) begin
      if (mProg < rows[mLvl]) mProg++;
      else begin
        mDone = 1;
        if (mLvl == 6) begin won = 1; mProg = 0; end
        else begin mLvl++; mProg = 1; end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("lvl", int'(lvl), mLvl);
      chk("prog", int'(prog), mProg);
      chk("playing", int'(playing), int'(inGame && !won && (mLvl % 2 == 0)));
      chk("levelDone", int'(done), int'(mDone));
      chk("win", int'(win), int'(inGame && won));
      chk("gameOver", int'(gameOver), int'(mOver));
    end
  end

  task automatic cyc(input bit r, input bit s, input bit t, input bit c);
    @(negedge clk);
    rst = r; start = s; tick = t; crash = c;
    @(posedge clk);
    modelStep(r, s, t, c);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    rst = 1; start = 0; tick = 0; crash = 0;
    cyc(1, 0, 0, 0);
    cmpEn = 1'b1;
    chk("lit reset lvl", int'(lvl), 0);
    chk("lit reset prog", int'(prog), 0);

    // Idle ignores tick and crash.
    cyc(0, 0, 1, 1);
    chk("lit idle ignores", int'(prog), 0);

    // Start, intro runs 1..8, then level 2 with one LevelDone pulse.
    cyc(0, 1, 0, 0);
    chk("lit start lvl", int'(lvl), 1);
    chk("lit start prog", int'(prog), 1);
    chk("lit intro playing", int'(playing), 0);
    cyc(0, 1, 1, 0);
    chk("lit start in run ignored", int'(prog), 2);
    ticks(6);
    chk("lit intro end prog", int'(prog), 8);
    ticks(1);
    chk("lit lvl2 code", int'(lvl), 2);
    chk("lit lvl2 prog", int'(prog), 1);
    chk("lit lvl2 done", int'(done), 1);
    chk("lit lvl2 playing", int'(playing), 1);
    cyc(0, 0, 0, 0);
    chk("lit done one cycle", int'(done), 0);

    // Crash beats tick in the same cycle.
    ticks(5);
    chk("lit lvl2 prog6", int'(prog), 6);
    cyc(0, 0, 1, 1);
    chk("lit crash+tick prog", int'(prog), 1);
    chk("lit crash+tick lvl", int'(lvl), 2);

    // Crash on a transition image is ignored.
    ticks(10);
    ticks(3);
    chk("lit lvl3 prog4", int'(prog), 4);
    cyc(0, 0, 0, 1);
    chk("lit odd crash lvl", int'(lvl), 3);
    chk("lit odd crash prog", int'(prog), 4);

    // Reset mid-run at level 4, row 7.
    ticks(5);
    ticks(6);
    chk("lit lvl4 code", int'(lvl), 4);
    chk("lit lvl4 prog7", int'(prog), 7);
    cyc(1, 1, 1, 1);
    chk("lit midrun reset lvl", int'(lvl), 0);
    chk("lit midrun reset prog", int'(prog), 0);
    chk("lit midrun reset playing", int'(playing), 0);

    // Full 69-tick run into WIN.
    cyc(0, 1, 0, 0);
    ticks(68);
    chk("lit last row lvl", int'(lvl), 6);
    chk("lit last row prog", int'(prog), 20);
    chk("lit last row win", int'(win), 0);
    ticks(1);
    chk("lit win lvl", int'(lvl), 6);
    chk("lit win prog", int'(prog), 0);
    chk("lit win flag", int'(win), 1);
    chk("lit win done", int'(done), 1);
    ticks(1);
    chk("lit win tick ignored", int'(prog), 0);
    cyc(0, 0, 0, 1);
    chk("lit win crash ignored", int'(win), 1);
    cyc(0, 1, 0, 0);
    chk("lit restart lvl", int'(lvl), 1);
    chk("lit restart prog", int'(prog), 1);
    chk("lit restart win", int'(win), 0);

`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
    // Three crashes at level 2 end the game.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    ticks(8);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("lit lives2 lvl", int'(lvl), 2);
    cyc(0, 0, 0, 1);
    chk("lit gameover lvl", int'(lvl), 0);
    chk("lit gameover prog", int'(prog), 0);
    chk("lit gameover pulse", int'(gameOver), 1);
    cyc(0, 0, 0, 0);
    chk("lit gameover one cycle", int'(gameOver), 0);
`endif

    cyc(0, 0, 0, 0);
    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
